// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED screen driver.
// Build option: define OLED_INVERT_EN to start the panel in inverse display mode.
package oled_pkg;

  typedef enum logic [2:0] {
    ST_POWER_UP,
    ST_RESET_LOW,
    ST_RESET_HIGH,
    ST_LOAD_CMD,
    ST_SEND,
    ST_CHECK_INIT,
    ST_LOAD_DATA,
    ST_CHECK_FRAME
  } oled_state_e;

  localparam int         INIT_CMD_COUNT = 21;
  localparam logic [4:0] INIT_CMD_LAST  = 5'(INIT_CMD_COUNT - 1);

`ifdef OLED_INVERT_EN
  localparam logic [7:0] DISP_MODE_CMD = 8'hA7;
`else
  localparam logic [7:0] DISP_MODE_CMD = 8'hA6;
`endif

  // Panel init list: clock divide, mux ratio, offset, start line, charge pump,
  // horizontal addressing over the full 128x64 window, remap, display mode, on.
  function automatic logic [7:0] init_cmd(input logic [4:0] idx);
    logic [7:0] cmd;
    case (idx)
      5'd0:    cmd = 8'hD5;
      5'd1:    cmd = 8'h80;
      5'd2:    cmd = 8'hA8;
      5'd3:    cmd = 8'h3F;
      5'd4:    cmd = 8'hD3;
      5'd5:    cmd = 8'h00;
      5'd6:    cmd = 8'h40;
      5'd7:    cmd = 8'h8D;
      5'd8:    cmd = 8'h14;
      5'd9:    cmd = 8'h20;
      5'd10:   cmd = 8'h00;
      5'd11:   cmd = 8'h21;
      5'd12:   cmd = 8'h00;
      5'd13:   cmd = 8'h7F;
      5'd14:   cmd = 8'h22;
      5'd15:   cmd = 8'h00;
      5'd16:   cmd = 8'h07;
      5'd17:   cmd = 8'hA1;
      5'd18:   cmd = 8'hC8;
      5'd19:   cmd = DISP_MODE_CMD;
      5'd20:   cmd = 8'hAF;
      default: cmd = 8'hE3;  // panel NOP, never reached
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/oled_spi_byte.sv
// SPI mode-0 byte shifter: loads a byte, shifts it out MSB first with an
// SCLK half-period of CLK_DIV clks, and pulses done in its final clk.
module oled_spi_byte #(
  parameter logic [7:0] CLK_DIV = 8'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  output logic       sclk,
  output logic       sdin,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = CLK_DIV - 8'd1;

  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic       sclk_q, sclk_d;
  logic       busy_q, busy_d;

  // Half-period timer, SCLK toggle, and shift on each falling edge.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sclk_d    = sclk_q;
    busy_d    = busy_q;
    done      = 1'b0;
    if (start) begin
      shreg_d   = din;
      bit_cnt_d = 3'd7;
      div_cnt_d = DIV_LAST;
      sclk_d    = 1'b0;
      busy_d    = 1'b1;
    end else if (busy_q) begin
      if (div_cnt_q == 8'd0) begin
        div_cnt_d = DIV_LAST;
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          sclk_d  = 1'b0;
          shreg_d = {shreg_q[6:0], 1'b0};
          if (bit_cnt_q == 3'd0) begin
            busy_d = 1'b0;
            done   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q - 3'd1;
          end
        end
      end else begin
        div_cnt_d = div_cnt_q - 8'd1;
      end
    end
  end

  // Shifter registers; reset drops any byte in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
    end
  end

  assign sclk = sclk_q;
  assign sdin = shreg_q[7];

endmodule

// File: rtl/oled_screen_driver.sv
// SSD1306-style OLED driver: power/reset sequencing, init command list,
// then continuous frame streaming from the text engine over SPI.
// Build option: OLED_INVERT_EN selects inverse display (see oled_pkg).
//
// state          | meaning
// ST_POWER_UP    | panel reset high, wait STARTUP_WAIT
// ST_RESET_LOW   | panel reset low, wait STARTUP_WAIT
// ST_RESET_HIGH  | panel reset high, wait STARTUP_WAIT
// ST_LOAD_CMD    | start shifting init command cmd_idx, dc=0
// ST_SEND        | byte shifting, cs low
// ST_CHECK_INIT  | cs high gap, next command or enter streaming
// ST_LOAD_DATA   | address held 2 clks, pixel byte captured on 2nd, dc=1
// ST_CHECK_FRAME | cs high gap, advance/wrap pixel address
module oled_screen_driver
  import oled_pkg::*;
#(
  parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
  parameter logic [7:0]  CLK_DIV      = 8'd4,
  parameter logic [10:0] FRAME_BYTES  = 11'd1024
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixelAddress,
  input  logic [7:0] pixelData,
  output logic       io_sclk,
  output logic       io_sdin,
  output logic       io_cs,
  output logic       io_dc,
  output logic       io_reset,
  output logic       init_done,
  output logic       frame_done
);

  localparam logic [31:0] STARTUP_LAST = STARTUP_WAIT - 32'd1;
  localparam logic [31:0] GAP_LAST     = {24'd0, CLK_DIV} - 32'd1;
  localparam logic [9:0]  ADDR_LAST    = 10'(FRAME_BYTES - 11'd1);

  oled_state_e state_q, state_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [4:0]  cmd_idx_q, cmd_idx_d;
  logic [9:0]  addr_q, addr_d;
  logic        init_done_q, init_done_d;
  logic        dc_q, dc_d;
  logic        cs_q, cs_d;
  logic        rst_pin_q, rst_pin_d;
  logic        frame_wrap;

  logic        spi_start;
  logic [7:0]  spi_din;
  logic        spi_done;

  oled_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk   (clk),
    .reset (reset),
    .start (spi_start),
    .din   (spi_din),
    .sclk  (io_sclk),
    .sdin  (io_sdin),
    .done  (spi_done)
  );

  // Next-state, counters and pin levels; pins follow the state being entered.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    cmd_idx_d   = cmd_idx_q;
    addr_d      = addr_q;
    init_done_d = init_done_q;
    spi_start   = 1'b0;
    spi_din     = 8'h00;
    frame_wrap  = 1'b0;

    case (state_q)
      ST_POWER_UP, ST_RESET_LOW, ST_RESET_HIGH: begin
        if (wait_cnt_q == STARTUP_LAST) begin
          wait_cnt_d = '0;
          case (state_q)
            ST_POWER_UP:  state_d = ST_RESET_LOW;
            ST_RESET_LOW: state_d = ST_RESET_HIGH;
            default:      state_d = ST_LOAD_CMD;
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_LOAD_CMD: begin
        spi_start = 1'b1;
        spi_din   = init_cmd(cmd_idx_q);
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (spi_done) begin
          wait_cnt_d = '0;
          state_d    = init_done_q ? ST_CHECK_FRAME : ST_CHECK_INIT;
        end
      end
      ST_CHECK_INIT: begin
        if (wait_cnt_q == GAP_LAST) begin
          wait_cnt_d = '0;
          if (cmd_idx_q < INIT_CMD_LAST) begin
            cmd_idx_d = cmd_idx_q + 5'd1;
            state_d   = ST_LOAD_CMD;
          end else begin
            init_done_d = 1'b1;
            state_d     = ST_LOAD_DATA;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_LOAD_DATA: begin
        // first clk lets the text engine's registered read settle
        if (wait_cnt_q == 32'd1) begin
          wait_cnt_d = '0;
          spi_start  = 1'b1;
          spi_din    = pixelData;
          state_d    = ST_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      ST_CHECK_FRAME: begin
        if (wait_cnt_q == GAP_LAST) begin
          wait_cnt_d = '0;
          state_d    = ST_LOAD_DATA;
          if (addr_q == ADDR_LAST) begin
            addr_d     = '0;
            frame_wrap = 1'b1;
          end else begin
            addr_d = addr_q + 10'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      default: state_d = ST_POWER_UP;
    endcase

    cs_d      = !(state_d == ST_LOAD_CMD || state_d == ST_LOAD_DATA || state_d == ST_SEND);
    rst_pin_d = (state_d != ST_RESET_LOW);
    if (state_d == ST_LOAD_CMD)       dc_d = 1'b0;
    else if (state_d == ST_LOAD_DATA) dc_d = 1'b1;
    else                              dc_d = dc_q;
  end

  // State and pin registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_POWER_UP;
      wait_cnt_q  <= '0;
      cmd_idx_q   <= '0;
      addr_q      <= '0;
      init_done_q <= 1'b0;
      dc_q        <= 1'b0;
      cs_q        <= 1'b1;
      rst_pin_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      cmd_idx_q   <= cmd_idx_d;
      addr_q      <= addr_d;
      init_done_q <= init_done_d;
      dc_q        <= dc_d;
      cs_q        <= cs_d;
      rst_pin_q   <= rst_pin_d;
    end
  end

  assign pixelAddress = addr_q;
  assign io_cs        = cs_q;
  assign io_dc        = dc_q;
  assign io_reset     = rst_pin_q;
  assign init_done    = init_done_q;
  assign frame_done   = frame_wrap;

endmodule

// File: tb/tb_oled_screen_driver.sv
// Bench for oled_screen_driver with short startup and CLK_DIV=1.
module tb_oled_screen_driver;

  localparam int NB1 = 1030;
  localparam int NB2 = 300;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pixelAddress;
  logic [7:0] pixelData;
  logic       io_sclk, io_sdin, io_cs, io_dc, io_reset, init_done, frame_done;

  oled_screen_driver #(
    .STARTUP_WAIT (32'd4),
    .CLK_DIV      (8'd1),
    .FRAME_BYTES  (11'd1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pixelAddress (pixelAddress),
    .pixelData    (pixelData),
    .io_sclk      (io_sclk),
    .io_sdin      (io_sdin),
    .io_cs        (io_cs),
    .io_dc        (io_dc),
    .io_reset     (io_reset),
    .init_done    (init_done),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // text engine: registered read, one clk latency
  logic       use_rand;
  logic [7:0] pix_mem [1024];
  always @(posedge clk) pixelData <= use_rand ? pix_mem[pixelAddress] : pixelAddress[7:0];

  // SPI slave model plus frame_done bookkeeping
  logic [7:0] rx_q [$];
  logic       rxdc_q [$];
  logic [9:0] rxad_q [$];
  logic       sclk_prev = 1'b0;
  logic       fd_prev = 1'b0;
  logic [7:0] sh = 8'h00;
  int         cur_bits = 0;
  int         fd_count = 0;
  int         fd_at = -1;
  logic [9:0] addr_after_wrap = 10'h3FF;

  always @(negedge clk) begin
    if (reset || io_cs) begin
      cur_bits = 0;
    end else if (io_sclk && !sclk_prev) begin
      sh = {sh[6:0], io_sdin};
      cur_bits++;
      if (cur_bits == 8) begin
        rx_q.push_back(sh);
        rxdc_q.push_back(io_dc);
        rxad_q.push_back(pixelAddress);
        cur_bits = 0;
      end
    end
    sclk_prev = io_sclk;
    if (fd_prev) addr_after_wrap = pixelAddress;
    if (frame_done) begin
      fd_count++;
      fd_at = rx_q.size();
    end
    fd_prev = frame_done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int c = 0;
    while (rx_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_init(input string tag);
    int c = 0;
    while (!init_done && c < 2000) begin
      tick();
      c++;
    end
    chk({tag, "_seen"}, 32'(init_done), 32'd1);
    chk({tag, "_count"}, 32'(rx_q.size()), 32'd21);
  endtask

  task automatic check_init_bytes(input logic [7:0] exp_cmds [21], input string tag);
    for (int i = 0; i < 21; i++) begin
      chk($sformatf("%s_cmd%0d", tag, i), 32'(rx_q[i]), 32'(exp_cmds[i]));
      chk($sformatf("%s_dc%0d", tag, i), 32'(rxdc_q[i]), 32'd0);
    end
  endtask

  task automatic check_data(input int nb, input logic rnd, input string tag);
    for (int i = 0; i < nb; i++) begin
      int a = i % 1024;
      logic [7:0] ev = rnd ? pix_mem[a] : 8'(a);
      chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[21 + i]), 32'(ev));
      chk($sformatf("%s_dc%0d", tag, i), 32'(rxdc_q[21 + i]), 32'd1);
      chk($sformatf("%s_addr%0d", tag, i), 32'(rxad_q[21 + i]), 32'(a));
    end
  endtask

  initial begin
    logic [7:0] exp_cmds [21];
    int cnt;
    int n_extra;
    exp_cmds = '{8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D, 8'h14, 8'h20, 8'h00,
                 8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07, 8'hA1, 8'hC8, 8'hA6, 8'hAF};
`ifdef OLED_INVERT_EN
    exp_cmds[19] = 8'hA7;
`endif
    for (int i = 0; i < 1024; i++) pix_mem[i] = 8'($urandom);
    use_rand = 1'b0;
    reset = 1'b1;
    repeat (3) tick();

    chk("rst_cs", 32'(io_cs), 32'd1);
    chk("rst_sclk", 32'(io_sclk), 32'd0);
    chk("rst_sdin", 32'(io_sdin), 32'd0);
    chk("rst_dc", 32'(io_dc), 32'd0);
    chk("rst_ioreset", 32'(io_reset), 32'd1);
    chk("rst_addr", 32'(pixelAddress), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // power/reset phases: 4 clks high, 4 low, high after; cs falls 12 clks in
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk($sformatf("pu_ioreset_k%0d", k), 32'(io_reset), (k >= 4 && k < 8) ? 32'd0 : 32'd1);
      chk($sformatf("pu_cs_k%0d", k), 32'(io_cs), (k < 12) ? 32'd1 : 32'd0);
    end

    wait_init("init");
    check_init_bytes(exp_cmds, "init");

    // one data byte frame on the wire: cs low for 2 + 16 clks, then 1 clk high
    cnt = 0;
    while (io_cs && cnt < 100) begin tick(); cnt++; end
    while (!io_cs && cnt < 100) begin tick(); cnt++; end
    cnt = 0;
    while (io_cs && cnt < 100) begin tick(); cnt++; end
    cnt = 0;
    while (!io_cs && cnt < 100) begin tick(); cnt++; end
    chk("cs_low_clks", 32'(cnt), 32'd18);
    cnt = 0;
    while (io_cs && cnt < 100) begin tick(); cnt++; end
    chk("cs_high_clks", 32'(cnt), 32'd1);

    wait_rx(21 + NB1, 40000, "data1_wait");
    check_data(NB1, 1'b0, "d1");
    chk("wrap_pulses", 32'(fd_count), 32'd1);
    chk("wrap_at_byte", 32'(fd_at), 32'd21 + 32'd1024);
    chk("wrap_addr0", 32'(addr_after_wrap), 32'd0);

    // reset in the middle of a data byte, after 3 bits
    n_extra = $urandom_range(2, 20);
    wait_rx(21 + NB1 + n_extra, 2000, "extra_wait");
    cnt = 0;
    while (cur_bits != 3 && cnt < 100) begin tick(); cnt++; end
    chk("mid_bits", 32'(cur_bits), 32'd3);
    reset = 1'b1;
    tick();
    chk("mid_cs", 32'(io_cs), 32'd1);
    chk("mid_sclk", 32'(io_sclk), 32'd0);
    chk("mid_sdin", 32'(io_sdin), 32'd0);
    chk("mid_addr", 32'(pixelAddress), 32'd0);
    chk("mid_init_done", 32'(init_done), 32'd0);
    chk("mid_ioreset", 32'(io_reset), 32'd1);
    rx_q.delete();
    rxdc_q.delete();
    rxad_q.delete();
    fd_count = 0;
    use_rand = 1'b1;
    tick();
    reset = 1'b0;
    cnt = 0;
    while (io_cs && cnt < 100) begin tick(); cnt++; end
    chk("re_cs_fall_clks", 32'(cnt), 32'd12);

    wait_init("reinit");
    check_init_bytes(exp_cmds, "reinit");
    wait_rx(21 + NB2, 20000, "data2_wait");
    check_data(NB2, 1'b1, "d2");
    chk("no_wrap2", 32'(fd_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
